// File: rtl/traffic_pkg.sv
// Shared types and helpers for the N-phase traffic signal controller.
// Sensor-to-duration mapping lives here so other controllers can reuse it.
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } state_e;

  localparam int unsigned SENS_MAX = 32;

  // Only the low n bits are meaningful; an idle phase gets the 1-tick minimum.
  function automatic int unsigned phase_dur_f(
    input logic [SENS_MAX-1:0] bits,
    input int unsigned         n,
    input int unsigned         t_full,
    input int unsigned         t_part
  );
    logic [SENS_MAX-1:0] mask;
    logic [SENS_MAX-1:0] act;
    mask = '0;
    for (int unsigned i = 0; i < SENS_MAX; i++) begin
      if (i < n) mask[i] = 1'b1;
    end
    act = bits & mask;
    if (act == mask && mask != '0) begin
      return t_full;
    end else if (act != '0) begin
      return t_part;
    end
    return 1;
  endfunction

endpackage

// File: rtl/rr_phase_pick.sv
// Combinational round-robin picker: first set demand bit at or after
// start_i, wrapping modulo N.
module rr_phase_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  demand_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int unsigned j;

  // Scan farthest-first so the nearest hit is the one left standing.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    j       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = 32'(start_i) + 32'(k);
      if (j >= 32'(N)) j = j - 32'(N);
      if (demand_i[IW'(j)]) begin
        found_o = 1'b1;
        idx_o   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Sensor-driven N-phase signal controller: GREEN -> YELLOW -> ALL_RED,
// round-robin over demanding phases, with emergency preemption.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_PHASES     = 4,
  parameter int SENS_PER_PHASE = 2,
  parameter int CNT_W          = 8,
  parameter int T_GREEN_FULL   = 60,
  parameter int T_GREEN_PART   = 30,
  parameter int T_YELLOW       = 3,
  parameter int T_ALLRED       = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 tick,
  input  logic [NUM_PHASES*SENS_PER_PHASE-1:0] sensors,
  input  logic                                 preempt_req,
  input  logic [$clog2(NUM_PHASES)-1:0]        preempt_phase,
  output logic [NUM_PHASES-1:0]                green,
  output logic [NUM_PHASES-1:0]                yellow,
  output logic                                 all_red,
  output logic [$clog2(NUM_PHASES)-1:0]        phase,
  output logic [CNT_W-1:0]                     remaining
);

  localparam int PW = $clog2(NUM_PHASES);
  localparam longint TMAX = longint'(1) << CNT_W;
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LD = CNT_W'(T_ALLRED - 1);

  if (NUM_PHASES < 2) begin : g_chk_np
    $error("NUM_PHASES must be at least 2");
  end
  if (SENS_PER_PHASE < 1 || SENS_PER_PHASE > SENS_MAX) begin : g_chk_sp
    $error("SENS_PER_PHASE out of range");
  end
  if (T_GREEN_FULL < 1 || longint'(T_GREEN_FULL) > TMAX) begin : g_chk_gf
    $error("T_GREEN_FULL out of range");
  end
  if (T_GREEN_PART < 1 || longint'(T_GREEN_PART) > TMAX) begin : g_chk_gp
    $error("T_GREEN_PART out of range");
  end
  if (T_YELLOW < 1 || longint'(T_YELLOW) > TMAX) begin : g_chk_y
    $error("T_YELLOW out of range");
  end
  if (T_ALLRED < 1 || longint'(T_ALLRED) > TMAX) begin : g_chk_ar
    $error("T_ALLRED out of range");
  end

  state_e            state_q, state_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [PW-1:0]     target_q, target_d;
  logic [CNT_W-1:0]  timer_q, timer_d;

  logic [NUM_PHASES-1:0] dem;
  logic [CNT_W-1:0]      load_v [NUM_PHASES];

  for (genvar p = 0; p < NUM_PHASES; p++) begin : g_ph
    logic [SENS_MAX-1:0] bits;
    assign bits = SENS_MAX'(sensors[p*SENS_PER_PHASE +: SENS_PER_PHASE]);
    assign dem[p] = |bits;
    assign load_v[p] = CNT_W'(phase_dur_f(bits, SENS_PER_PHASE,
                                          T_GREEN_FULL, T_GREEN_PART) - 1);
  end

  // Indices that do not name a real phase never preempt.
  logic [2**PW-1:0] pp_ok;
  for (genvar i = 0; i < 2**PW; i++) begin : g_pok
    assign pp_ok[i] = (i < NUM_PHASES);
  end

  logic          pre_v;
  logic [PW-1:0] pre_p;
  assign pre_v = preempt_req & pp_ok[preempt_phase];
  assign pre_p = preempt_phase;

  logic [NUM_PHASES-1:0] rr_dem;
  logic [PW-1:0]         rr_start;
  logic                  rr_found;
  logic [PW-1:0]         rr_idx;

  assign rr_dem   = dem & ~(NUM_PHASES'(1) << phase_q);
  assign rr_start = (phase_q == PW'(NUM_PHASES - 1)) ? '0 : phase_q + 1'b1;

  rr_phase_pick #(
    .N  (NUM_PHASES),
    .IW (PW)
  ) u_pick (
    .demand_i (rr_dem),
    .start_i  (rr_start),
    .found_o  (rr_found),
    .idx_o    (rr_idx)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    target_d = target_q;
    timer_d  = timer_q;
    if (tick) begin
      unique case (state_q)
        GREEN: begin
          if (pre_v) begin
            if (pre_p != phase_q) begin
              state_d  = YELLOW;
              target_d = pre_p;
              timer_d  = Y_LD;
            end
          end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else if (rr_found) begin
            state_d  = YELLOW;
            target_d = rr_idx;
            timer_d  = Y_LD;
          end else begin
            // Idle phase yields 0 here, so no-demand simply re-checks.
            timer_d = load_v[phase_q];
          end
        end
        YELLOW: begin
          if (pre_v) target_d = pre_p;
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = ALL_RED;
            timer_d = AR_LD;
          end
        end
        ALL_RED: begin
          if (pre_v) target_d = pre_p;
          if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
          end else begin
            state_d = GREEN;
            phase_d = pre_v ? pre_p : target_q;
            timer_d = load_v[phase_d];
          end
        end
        default: state_d = GREEN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= GREEN;
      phase_q  <= '0;
      target_q <= '0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      target_q <= target_d;
      timer_q  <= timer_d;
    end
  end

  assign green     = (state_q == GREEN) ? (NUM_PHASES'(1) << phase_q) : '0;
  assign yellow    = (state_q == YELLOW) ? (NUM_PHASES'(1) << phase_q) : '0;
  assign all_red   = (state_q == ALL_RED);
  assign phase     = phase_q;
  assign remaining = timer_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl with default parameters.
// Expected lamp/phase/timer values are hand-derived per step.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [7:0] sensors;
  logic       preempt_req;
  logic [1:0] preempt_phase;
  logic [3:0] green;
  logic [3:0] yellow;
  logic       all_red;
  logic [1:0] phase;
  logic [7:0] remaining;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  logic saw_y;

  traffic_phase_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .tick          (tick),
    .sensors       (sensors),
    .preempt_req   (preempt_req),
    .preempt_phase (preempt_phase),
    .green         (green),
    .yellow        (yellow),
    .all_red       (all_red),
    .phase         (phase),
    .remaining     (remaining)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input logic [3:0] g,
                        input logic [3:0] y, input logic ar,
                        input logic [1:0] ph, input logic [7:0] rem);
    chk({tag, ".green"}, 32'(green), 32'(g));
    chk({tag, ".yellow"}, 32'(yellow), 32'(y));
    chk({tag, ".all_red"}, 32'(all_red), 32'(ar));
    chk({tag, ".phase"}, 32'(phase), 32'(ph));
    chk({tag, ".remaining"}, 32'(remaining), 32'(rem));
  endtask

  // One tick pulse followed by an idle cycle; returns on a negedge.
  task automatic tk(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    sensors = '0;
    preempt_req = 1'b0;
    preempt_phase = '0;
    @(negedge clk);
    chk_st("reset", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      tk(1);
      chk_st("idle", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    end

    sensors = 8'b0000_0100;
    tk(1);
    chk_st("p1_y0", 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd2);
    repeat (3) @(negedge clk);
    chk("notick_hold", 32'(remaining), 32'd2);
    tk(2);
    chk_st("p1_y2", 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd0);
    tk(1);
    chk_st("p1_ar", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd0);
    tk(1);
    chk_st("p1_g", 4'b0010, 4'b0000, 1'b0, 2'd1, 8'd29);

    sensors = 8'b1100_0001;
    tk(29);
    chk_st("p1_end", 4'b0010, 4'b0000, 1'b0, 2'd1, 8'd0);
    tk(1);
    chk_st("skip2_y", 4'b0000, 4'b0010, 1'b0, 2'd1, 8'd2);
    tk(3);
    chk_st("skip2_ar", 4'b0000, 4'b0000, 1'b1, 2'd1, 8'd0);
    tk(1);
    chk_st("p3_g", 4'b1000, 4'b0000, 1'b0, 2'd3, 8'd59);
    tk(59);
    chk("p3_end", 32'(remaining), 32'd0);
    tk(1);
    chk_st("p3_y", 4'b0000, 4'b1000, 1'b0, 2'd3, 8'd2);
    tk(4);
    chk_st("wrap_p0_g", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd29);

    sensors = 8'b0000_0011;
    tk(29);
    chk_st("p0_end", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    tk(1);
    chk_st("p0_reload", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd59);
    saw_y = 1'b0;
    for (int i = 0; i < 59; i++) begin
      tk(1);
      if (yellow != 4'b0000) saw_y = 1'b1;
    end
    chk("no_yellow", 32'(saw_y), 32'd0);
    chk("p0_end2", 32'(remaining), 32'd0);
    tk(1);
    chk_st("p0_reload2", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd59);

    tk(19);
    chk_st("p0_r40", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd40);
    preempt_req = 1'b1;
    preempt_phase = 2'd2;
    tk(1);
    chk_st("pre_y", 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd2);
    tk(3);
    chk_st("pre_ar", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd0);
    tk(1);
    chk_st("pre_g", 4'b0100, 4'b0000, 1'b0, 2'd2, 8'd0);
    tk(5);
    chk_st("pre_hold", 4'b0100, 4'b0000, 1'b0, 2'd2, 8'd0);
    preempt_req = 1'b0;
    tk(1);
    chk_st("rel_y", 4'b0000, 4'b0100, 1'b0, 2'd2, 8'd2);
    tk(4);
    chk_st("rel_g0", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd59);

    preempt_req = 1'b1;
    preempt_phase = 2'd1;
    tk(1);
    chk_st("pre1_y", 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd2);
    preempt_phase = 2'd3;
    tk(1);
    preempt_req = 1'b0;
    tk(1);
    chk_st("retgt_y", 4'b0000, 4'b0001, 1'b0, 2'd0, 8'd0);
    tk(1);
    chk_st("retgt_ar", 4'b0000, 4'b0000, 1'b1, 2'd0, 8'd0);
    tk(1);
    chk_st("retgt_g3", 4'b1000, 4'b0000, 1'b0, 2'd3, 8'd0);
    tk(1);
    chk_st("p3_to_y", 4'b0000, 4'b1000, 1'b0, 2'd3, 8'd2);

    #2;
    rst = 1'b1;
    #1;
    chk_st("async_rst", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tk(1);
    chk_st("post_rst", 4'b0001, 4'b0000, 1'b0, 2'd0, 8'd59);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
